memory_access: RTL and testbench

- Memory/writeback-side stage of the 3-stage RISC-V core; consumes everything the execute stage emits.
- Registers the E→M pipeline boundary and performs loads and stores over a req/ack data-memory handshake.
- Handles sub-word alignment, lane steering and load extension, and selects the write-back result.
- Produces the M/W-stage values the hazard unit and forwarding muxes consume: alu_result_m, result_w, rd_m, rd_w, reg_write_m, reg_write_w.
- Asserts stall_m while a memory access is outstanding.

---
 rtl/memory_access_pkg.sv | 31 +++
 rtl/memory_access_align.sv | 59 +++++
 rtl/memory_access.sv | 188 ++++++++++++++++++
 tb/tb_memory_access.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared constants for the memory/write-back stage.
//   - result-source and funct3 encodings as decoded by the stage
//   - access-size codes (funct3[1:0]) and the misalignment rule
//   - FSM state encoding for the data-memory handshake
package memory_access_pkg;

  localparam logic [1:0] RES_SRC_ALU  = 2'b00;
  localparam logic [1:0] RES_SRC_LOAD = 2'b01;
  localparam logic [1:0] RES_SRC_PC4  = 2'b10;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Halfwords must sit on even addresses, words on multiples of 4.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/memory_access_align.sv
// load_store_align: combinational sub-word handling for the M stage.
//   funct3, addr_lo     : access size/signedness and byte offset
//   store_data          : store operand -> be (byte enables), wdata (lane-replicated)
//   load_raw            : memory word   -> load_data (selected and extended)
//   misaligned          : access violates natural alignment
module load_store_align
  import memory_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]              funct3,
  input  logic [1:0]              addr_lo,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [DATA_WIDTH-1:0]   load_raw,
  output logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    misaligned
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic [1:0]                 size;
  logic [NUM_LANES-1:0][7:0]  sd_lane;
  logic [NUM_LANES-1:0][7:0]  wd_lane;
  logic [7:0]                 ld_byte;
  logic [15:0]                ld_half;

  assign size    = funct3[1:0];
  assign sd_lane = store_data;

  // Each byte lane picks its source byte: byte stores replicate lane 0 everywhere,
  // halfword stores replicate the low halfword into both halves. Size 11 acts as a word.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign be[i] = (size == SIZE_B) ? (addr_lo == 2'(i)) :
                   (size == SIZE_H) ? (addr_lo[1] == 1'(i / 2)) : 1'b1;
    assign wd_lane[i] = (size == SIZE_B) ? sd_lane[0] :
                        (size == SIZE_H) ? sd_lane[i % 2] : sd_lane[i];
  end

  assign wdata   = wd_lane;
  assign ld_byte = load_raw[{addr_lo, 3'b000} +: 8];
  assign ld_half = load_raw[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data = load_raw;
    case (funct3)
      FUNCT3_B:  load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      FUNCT3_H:  load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      FUNCT3_BU: load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      FUNCT3_HU: load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      FUNCT3_W:  load_data = load_raw;
      default:   load_data = load_raw;
    endcase
  end

  assign misaligned = is_misaligned(size, addr_lo);

endmodule

// File: rtl/memory_access.sv
// memory_access: M/W stage of the 3-stage core.
//   *_e inputs      : execute-stage outputs, captured into M when stall_m=0
//   dmem_*          : req/ack data-memory port (ack may come in the request cycle)
//   stall_m         : access outstanding; upstream and the E->M register hold
//   *_m outputs     : M-stage values for forwarding / hazard detection
//   *_w outputs     : registered write-back slot; misaligned_w / bus_err_w pulse with it
module memory_access
  import memory_access_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write_e,
  input  logic [1:0]               res_src_e,
  input  logic                     mem_write_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [3:0]               dmem_be,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  input  logic                     dmem_ack,
  output logic                     stall_m,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [4:0]               rd_m,
  output logic                     reg_write_m,
  output logic [DATA_WIDTH-1:0]    result_w,
  output logic [4:0]               rd_w,
  output logic                     reg_write_w,
  output logic                     misaligned_w,
  output logic                     bus_err_w
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef struct packed {
    logic                     reg_write;
    logic [1:0]               res_src;
    logic                     mem_write;
    logic [2:0]               funct3;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [4:0]               rd;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
  } em_t;

  typedef struct packed {
    logic                  reg_write;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] result;
    logic                  misaligned;
    logic                  bus_err;
  } mw_t;

  em_t                   m_q, e_in;
  mw_t                   w_q, w_d;
  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_load, is_store, mem_op, mis_raw, mis_op, mem_req;
  logic                  timeout_hit, abort;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata, load_data, result_m;

  assign e_in = '{reg_write:  reg_write_e,  res_src:    res_src_e,
                  mem_write:  mem_write_e,  funct3:     funct3_e,
                  alu_result: alu_result_e, write_data: write_data_e,
                  rd:         rd_e,         pc_plus4:   pc_plus4_e};

  always_ff @(posedge clk) begin
    if (!rst_n)        m_q <= '0;
    else if (!stall_m) m_q <= e_in;
  end

  load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (m_q.funct3),
    .addr_lo    (m_q.alu_result[1:0]),
    .store_data (m_q.write_data),
    .load_raw   (dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data),
    .misaligned (mis_raw)
  );

  assign is_load  = (m_q.res_src == RES_SRC_LOAD);
  assign is_store = m_q.mem_write;
  assign mem_op   = is_load | is_store;
  assign mis_op   = mem_op & mis_raw;
  assign mem_req  = mem_op & ~mis_raw;

  // M is frozen while waiting, so the request and its address/data stay stable.
  assign dmem_req   = mem_req;
  assign dmem_we    = mem_req & is_store;
  assign dmem_addr  = ADDRESS_WIDTH'({m_q.alu_result[DATA_WIDTH-1:2], 2'b00});
  assign dmem_be    = (mem_req & is_store) ? lane_be : 4'b0000;
  assign dmem_wdata = (mem_req & is_store) ? lane_wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle that completes an access (ack or abort) is never a stall cycle,
  // so the op retires into W on that same edge. Ack beats the abort.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_m     = 1'b0;
    abort       = 1'b0;
    timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (mem_req && !dmem_ack) begin
          stall_m = 1'b1;
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall_m = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    result_m = m_q.alu_result;
    case (m_q.res_src)
      RES_SRC_LOAD: result_m = load_data;
      RES_SRC_PC4:  result_m = DATA_WIDTH'(m_q.pc_plus4);
      default:      result_m = m_q.alu_result;
    endcase
  end

  // A stalled cycle hands W a bubble; failed accesses retire without a register write.
  always_comb begin
    w_d = '0;
    if (!stall_m) begin
      w_d.reg_write  = m_q.reg_write & ~mis_op & ~abort;
      w_d.rd         = m_q.rd;
      w_d.result     = result_m;
      w_d.misaligned = mis_op;
      w_d.bus_err    = abort;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) w_q <= '0;
    else        w_q <= w_d;
  end

  assign alu_result_m = m_q.alu_result;
  assign rd_m         = m_q.rd;
  assign reg_write_m  = m_q.reg_write;
  assign result_w     = w_q.result;
  assign rd_w         = w_q.rd;
  assign reg_write_w  = w_q.reg_write;
  assign misaligned_w = w_q.misaligned;
  assign bus_err_w    = w_q.bus_err;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_write_e = 1'b0;
  logic [1:0]  res_src_e = '0;
  logic        mem_write_e = 1'b0;
  logic [2:0]  funct3_e = '0;
  logic [31:0] alu_result_e = '0, write_data_e = '0, pc_plus4_e = '0;
  logic [4:0]  rd_e = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic        stall_m, reg_write_m, reg_write_w, misaligned_w, bus_err_w;
  logic [31:0] alu_result_m, result_w;
  logic [4:0]  rd_m, rd_w;

  memory_access #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_e(reg_write_e), .res_src_e(res_src_e), .mem_write_e(mem_write_e),
    .funct3_e(funct3_e), .alu_result_e(alu_result_e), .write_data_e(write_data_e),
    .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_m(stall_m), .alu_result_m(alu_result_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .result_w(result_w), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .misaligned_w(misaligned_w), .bus_err_w(bus_err_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  src;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } op_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rw;
    logic [31:0] res;
    logic        mis;
    logic        berr;
    int          stalls;
  } exp_t;

  typedef struct {
    op_t         op;
    int          ack_after;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];
  logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic op_t mk_op(input logic rw, input logic [1:0] src, input logic mw,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] rd,
                                input logic [31:0] pc4);
    op_t o;
    o.rw = rw; o.src = src; o.mw = mw; o.f3 = f3;
    o.alu = alu; o.wd = wd; o.rd = rd; o.pc4 = pc4;
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic req, input logic [31:0] addr, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic rw, input logic [31:0] res,
                                  input logic mis, input logic berr, input int stalls);
    exp_t e;
    e.req = req; e.addr = addr; e.be = be; e.wdata = wdata; e.rw = rw;
    e.res = res; e.mis = mis; e.berr = berr; e.stalls = stalls;
    return e;
  endfunction

  task automatic add_vec(input op_t o, input int ack, input logic [31:0] rdata, input exp_t e);
    vec_t v;
    v.op = o; v.ack_after = ack; v.rdata = rdata; v.e = e;
    vq.push_back(v);
  endtask

  // Reference: what an access should look like, from the ISA rules.
  function automatic logic [31:0] load_val(input logic [2:0] f3, input int off, input logic [31:0] r);
    int b, h;
    b = int'((r >> (8 * off)) & 32'hFF);
    h = int'((r >> (16 * (off / 2))) & 32'hFFFF);
    case (f3)
      3'd0:    return 32'((b >= 128) ? b - 256 : b);
      3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return r;
    endcase
  endfunction

  function automatic exp_t model(input op_t o, input int ack, input logic [31:0] rdata);
    exp_t e;
    int   off, sz;
    bit   ld, st, mis;
    ld  = (o.src == 2'd1);
    st  = o.mw;
    off = int'(o.alu % 4);
    sz  = int'(o.f3 % 4);
    mis = (ld || st) && ((sz == 1 && off % 2 != 0) || (sz == 2 && off != 0));
    e.req   = (ld || st) && !mis;
    e.addr  = o.alu - 32'(off);
    if (!(e.req && st))  e.be = 4'd0;
    else if (sz == 0)    e.be = 4'(1 << off);
    else if (sz == 1)    e.be = (off >= 2) ? 4'b1100 : 4'b0011;
    else                 e.be = 4'b1111;
    if (sz == 0)         e.wdata = (o.wd & 32'hFF) * 32'h01010101;
    else if (sz == 1)    e.wdata = (o.wd & 32'hFFFF) * 32'h00010001;
    else                 e.wdata = o.wd;
    e.stalls = !e.req ? 0 : (ack < 0 ? TO : ack);
    e.berr   = e.req && (ack < 0);
    e.mis    = mis;
    e.rw     = o.rw && !mis && !e.berr;
    case (o.src)
      2'd1:    e.res = load_val(o.f3, off, rdata);
      2'd2:    e.res = o.pc4;
      default: e.res = o.alu;
    endcase
    return e;
  endfunction

  task automatic drive(input op_t o);
    reg_write_e = o.rw; res_src_e = o.src; mem_write_e = o.mw; funct3_e = o.f3;
    alu_result_e = o.alu; write_data_e = o.wd; rd_e = o.rd; pc_plus4_e = o.pc4;
  endtask

  // Issue one op, answer the memory after ack_after cycles (-1: never), check the
  // request every cycle it is in M and the W slot right after it retires.
  task automatic exec(input string nm, input op_t o, input int ack_after,
                      input logic [31:0] rdata, input exp_t e);
    int cyc;
    drive(o);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    drive(mk_op(0, 0, 0, 0, 0, 0, 0, 0));
    cyc = 0;
    forever begin
      dmem_ack   = (cyc == ack_after);
      dmem_rdata = (cyc == ack_after) ? rdata : $urandom();
      #1;
      chk({nm, " req"}, 32'(dmem_req), 32'(e.req));
      if (e.req) begin
        chk({nm, " addr"}, dmem_addr, e.addr);
        chk({nm, " we"}, 32'(dmem_we), 32'(o.mw));
        chk({nm, " be"}, 32'(dmem_be), 32'(e.be));
        if (o.mw) chk({nm, " wdata"}, dmem_wdata, e.wdata);
      end
      chk({nm, " stall"}, 32'(stall_m), 32'(cyc < e.stalls));
      chk({nm, " w_bubble"}, 32'(reg_write_w), 32'd0);
      if (cyc >= e.stalls) break;
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk({nm, " reg_write_w"}, 32'(reg_write_w), 32'(e.rw));
    chk({nm, " rd_w"}, 32'(rd_w), 32'(o.rd));
    if (e.rw) chk({nm, " result_w"}, result_w, e.res);
    chk({nm, " misaligned_w"}, 32'(misaligned_w), 32'(e.mis));
    chk({nm, " bus_err_w"}, 32'(bus_err_w), 32'(e.berr));
  endtask

  initial begin
    op_t  o;
    exp_t e;
    int   kind, ack;
    logic [31:0] rd;

    // ---- vector table: {op, ack delay, read data, expected} ----
    add_vec(mk_op(0, 0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0), 0, 32'h0,
            mk_exp(1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    add_vec(mk_op(1, 1, 0, 3'd0, 32'h103, 0, 7, 0), 3, 32'h80FFFF12,
            mk_exp(1, 32'h100, 4'b0000, 0, 1, 32'hFFFFFF80, 0, 0, 3));
    add_vec(mk_op(1, 1, 0, 3'd4, 32'h103, 0, 8, 0), 3, 32'h80FFFF12,
            mk_exp(1, 32'h100, 4'b0000, 0, 1, 32'h00000080, 0, 0, 3));
    add_vec(mk_op(0, 0, 1, 3'd1, 32'h202, 32'h1234ABCD, 0, 0), 1, 32'h0,
            mk_exp(1, 32'h200, 4'b1100, 32'hABCDABCD, 0, 0, 0, 0, 1));
    add_vec(mk_op(1, 1, 0, 3'd2, 32'h101, 0, 9, 0), -1, 32'h0,
            mk_exp(0, 32'h100, 4'b0000, 0, 0, 0, 1, 0, 0));
    add_vec(mk_op(1, 1, 0, 3'd2, 32'h300, 0, 10, 0), -1, 32'h0,
            mk_exp(1, 32'h300, 4'b0000, 0, 0, 0, 0, 1, TO));
    add_vec(mk_op(1, 1, 0, 3'd1, 32'h102, 0, 11, 0), 0, 32'h80010000,
            mk_exp(1, 32'h100, 4'b0000, 0, 1, 32'hFFFF8001, 0, 0, 0));
    add_vec(mk_op(1, 1, 0, 3'd5, 32'h100, 0, 12, 0), 2, 32'h1234F00F,
            mk_exp(1, 32'h100, 4'b0000, 0, 1, 32'h0000F00F, 0, 0, 2));
    add_vec(mk_op(0, 0, 1, 3'd0, 32'h101, 32'h776655AB, 0, 0), 0, 32'h0,
            mk_exp(1, 32'h100, 4'b0010, 32'hABABABAB, 0, 0, 0, 0, 0));
    add_vec(mk_op(1, 2, 0, 3'd0, 32'h55, 0, 13, 32'h44), -1, 32'h0,
            mk_exp(0, 0, 0, 0, 1, 32'h44, 0, 0, 0));
    add_vec(mk_op(1, 3, 0, 3'd0, 32'h1234, 0, 14, 32'h8), -1, 32'h0,
            mk_exp(0, 0, 0, 0, 1, 32'h1234, 0, 0, 0));
    add_vec(mk_op(0, 0, 1, 3'd1, 32'h201, 32'hFFFF, 0, 0), -1, 32'h0,
            mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
    add_vec(mk_op(1, 1, 0, 3'd2, 32'h204, 0, 15, 0), 2, 32'hCAFEF00D,
            mk_exp(1, 32'h204, 4'b0000, 0, 1, 32'hCAFEF00D, 0, 0, 2));
    add_vec(mk_op(1, 1, 0, 3'd3, 32'h208, 0, 16, 0), 0, 32'h0BADF00D,
            mk_exp(1, 32'h208, 4'b0000, 0, 1, 32'h0BADF00D, 0, 0, 0));

    // ---- reset: a live op on E must not leak into M or W ----
    drive(mk_op(1, 1, 1, 3'd2, 32'h40, 32'h11, 5, 32'h99));
    repeat (2) @(posedge clk);
    #1;
    chk("rst dmem_req", 32'(dmem_req), 0);
    chk("rst stall_m", 32'(stall_m), 0);
    chk("rst dmem_addr", dmem_addr, 0);
    chk("rst dmem_be", 32'(dmem_be), 0);
    chk("rst dmem_wdata", dmem_wdata, 0);
    chk("rst alu_result_m", alu_result_m, 0);
    chk("rst rd_m", 32'(rd_m), 0);
    chk("rst reg_write_m", 32'(reg_write_m), 0);
    chk("rst result_w", result_w, 0);
    chk("rst rd_w", 32'(rd_w), 0);
    chk("rst reg_write_w", 32'(reg_write_w), 0);
    chk("rst pulses", 32'({misaligned_w, bus_err_w}), 0);
    drive(mk_op(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // ---- table ----
    foreach (vq[i])
      exec($sformatf("vec%0d", i), vq[i].op, vq[i].ack_after, vq[i].rdata, vq[i].e);

    // ---- back-to-back: store acked immediately, ALU op right behind it ----
    drive(mk_op(0, 0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0));
    @(posedge clk); #1;
    drive(mk_op(1, 0, 0, 3'd0, 32'h7, 0, 5, 0));
    dmem_ack = 1'b1;
    #1;
    chk("b2b sw stall", 32'(stall_m), 0);
    chk("b2b sw req", 32'(dmem_req), 1);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    drive(mk_op(0, 0, 0, 0, 0, 0, 0, 0));
    chk("b2b alu in M", alu_result_m, 32'h7);
    chk("b2b alu stall", 32'(stall_m), 0);
    @(posedge clk); #1;
    chk("b2b result_w", result_w, 32'h7);
    chk("b2b rd_w", 32'(rd_w), 5);
    chk("b2b reg_write_w", 32'(reg_write_w), 1);

    // ---- reset in the second WAIT cycle, then a late ack ----
    drive(mk_op(1, 1, 0, 3'd2, 32'h400, 0, 3, 0));
    @(posedge clk); #1;
    drive(mk_op(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rstwait stall before", 32'(stall_m), 1);
    @(posedge clk); #1;
    chk("rstwait req", 32'(dmem_req), 0);
    chk("rstwait stall", 32'(stall_m), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late ack req", 32'(dmem_req), 0);
      chk("late ack stall", 32'(stall_m), 0);
      chk("late ack W", {result_w[26:0], rd_w}, 0);
      chk("late ack W ctl", 32'({reg_write_w, misaligned_w, bus_err_w}), 0);
    end
    dmem_ack = 1'b0;
    exec("post-rst", vq[12].op, vq[12].ack_after, vq[12].rdata, vq[12].e);

    // ---- randomized ops against the reference model ----
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 3));
      o = mk_op(1'($urandom_range(0, 1)), 0, 0, f3s[$urandom_range(0, 4)], $urandom(),
                $urandom(), 5'($urandom_range(1, 31)), $urandom());
      case (kind)
        0: o.src = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0;
        1: begin o.src = 2'd1; o.alu = 32'($urandom_range(0, 1023)); end
        2: begin o.mw = 1'b1; o.alu = 32'($urandom_range(0, 1023)); end
        default: o.src = 2'd2;
      endcase
      ack = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      rd  = $urandom();
      e = model(o, ack, rd);
      if (!e.req) begin
        ack = -1;
        e = model(o, ack, rd);
      end
      exec($sformatf("rnd%0d", n), o, ack, rd, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
